// File: rtl/pong_pkg.sv
// Purpose: shared types and constants for the fronton game controller.
// Latency: none; this package holds declarations only.
// Backpressure: not applicable.
package pong_pkg;

  // Game controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  // Visible display area in pixels.
  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;

  // Width of the ball step output.
  localparam int SPEED_W = 5;

endpackage

// File: rtl/fronton_game_ctrl_btn_sync.sv
// Purpose: 2-flop synchroniser for the raw start button plus rising-edge detect.
// Latency: a level change on i_btn shows as a one-cycle o_rise two clocks later.
// Backpressure: none; o_rise is a free-running pulse.
module btn_sync
  import pong_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // Two metastability stages, then a delayed copy for edge detection.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_rise = r_sync2 & ~r_prev;

endmodule

// File: rtl/fronton_game_ctrl.sv
// Purpose: fronton game FSM (IDLE/SERVE/PLAY/OVER) with lives, score and ball speed.
// Latency: every sampled event updates the registered outputs one clock later.
// Backpressure: none; pulse inputs are consumed in the cycle they arrive.
// Optional feature: define SPEED_RAMP_EN to raise speed every HITS_PER_STEP paddle hits.
module fronton_game_ctrl
  import pong_pkg::*;
#(
  parameter int LIVES         = 3,
  parameter int SPEED_INIT    = 2,
  parameter int SPEED_MAX     = 8,
  parameter int HITS_PER_STEP = 4,
  parameter int SERVE_FRAMES  = 60
) (
  input  logic               px_clk,
  input  logic               reset,
  input  logic               endframe,
  input  logic               start_btn,
  input  logic               paddle_hit,
  input  logic               ball_miss,
  output logic               run,
  output logic               serve,
  output logic [SPEED_W-1:0] speed,
  output logic [1:0]         lives,
  output logic [7:0]         counter,
  output logic               game_over
);

  localparam int FRAME_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [FRAME_W-1:0]   r_frame_cnt;
  logic [FRAME_W-1:0]   w_frame_cnt_nxt;
  logic [1:0]           r_lives;
  logic [1:0]           w_lives_nxt;
  logic [7:0]           r_counter;
  logic [7:0]           w_counter_nxt;
  logic [SPEED_W-1:0]   r_speed;
  logic [SPEED_W-1:0]   w_speed_nxt;
  logic                 r_serve;
  logic                 w_serve_nxt;
  logic                 r_run;
  logic                 r_game_over;
  logic                 w_start;
  logic                 w_new_game;
  logic                 w_play_hit;

  btn_sync u_btn_sync (
    .i_clk   (px_clk),
    .i_reset (reset),
    .i_btn   (start_btn),
    .o_rise  (w_start)
  );

  // Next-state and next-output decode; a miss always wins over a hit in the same cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_frame_cnt_nxt = r_frame_cnt;
    w_lives_nxt     = r_lives;
    w_counter_nxt   = r_counter;
    w_serve_nxt     = 1'b0;
    w_new_game      = 1'b0;
    w_play_hit      = 1'b0;
    case (r_state)
      ST_IDLE, ST_OVER: begin
        if (w_start) begin
          w_state_nxt     = ST_SERVE;
          w_frame_cnt_nxt = '0;
          w_lives_nxt     = 2'(LIVES);
          w_counter_nxt   = '0;
          w_serve_nxt     = 1'b1;
          w_new_game      = 1'b1;
        end
      end
      ST_SERVE: begin
        if (endframe) begin
          if (r_frame_cnt == FRAME_W'(SERVE_FRAMES - 1)) begin
            w_state_nxt     = ST_PLAY;
            w_frame_cnt_nxt = '0;
          end else begin
            w_frame_cnt_nxt = r_frame_cnt + FRAME_W'(1);
          end
        end
      end
      ST_PLAY: begin
        if (ball_miss) begin
          if (r_lives > 2'd1) begin
            w_lives_nxt     = r_lives - 2'd1;
            w_state_nxt     = ST_SERVE;
            w_frame_cnt_nxt = '0;
            w_serve_nxt     = 1'b1;
          end else begin
            w_lives_nxt = 2'd0;
            w_state_nxt = ST_OVER;
          end
        end else if (paddle_hit) begin
          w_play_hit = 1'b1;
          if (r_counter != 8'hFF) begin
            w_counter_nxt = r_counter + 8'd1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef SPEED_RAMP_EN
  localparam int HIT_W = (HITS_PER_STEP > 1) ? $clog2(HITS_PER_STEP) : 1;

  logic [HIT_W-1:0] r_hit_cnt;
  logic [HIT_W-1:0] w_hit_cnt_nxt;

  // Speed ramp: every HITS_PER_STEP-th hit in a game bumps speed up to SPEED_MAX.
  always_comb begin
    w_hit_cnt_nxt = r_hit_cnt;
    w_speed_nxt   = r_speed;
    if (w_new_game) begin
      w_hit_cnt_nxt = '0;
      w_speed_nxt   = SPEED_W'(SPEED_INIT);
    end else if (w_play_hit) begin
      if (r_hit_cnt == HIT_W'(HITS_PER_STEP - 1)) begin
        w_hit_cnt_nxt = '0;
        if (r_speed < SPEED_W'(SPEED_MAX)) begin
          w_speed_nxt = r_speed + SPEED_W'(1);
        end
      end else begin
        w_hit_cnt_nxt = r_hit_cnt + HIT_W'(1);
      end
    end
  end

  // Hit counter register for the speed ramp.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      r_hit_cnt <= '0;
    end else begin
      r_hit_cnt <= w_hit_cnt_nxt;
    end
  end
`else
  logic w_unused_ramp_cfg;

  assign w_speed_nxt       = SPEED_W'(SPEED_INIT);
  assign w_unused_ramp_cfg = w_new_game ^ w_play_hit ^ (HITS_PER_STEP > 0) ^ (SPEED_MAX > 0);
`endif

  // State register and registered outputs; reset overrides every event.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_frame_cnt <= '0;
      r_lives     <= 2'd0;
      r_counter   <= 8'd0;
      r_speed     <= SPEED_W'(SPEED_INIT);
      r_serve     <= 1'b0;
      r_run       <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_lives     <= w_lives_nxt;
      r_counter   <= w_counter_nxt;
      r_speed     <= w_speed_nxt;
      r_serve     <= w_serve_nxt;
      r_run       <= (w_state_nxt == ST_PLAY);
      r_game_over <= (w_state_nxt == ST_OVER);
    end
  end

  assign run       = r_run;
  assign serve     = r_serve;
  assign speed     = r_speed;
  assign lives     = r_lives;
  assign counter   = r_counter;
  assign game_over = r_game_over;

endmodule
